// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: DEPTH-entry FIFO with valid/ready on both sides, synchronous flush and occupancy.
// Optional stall counter port (stall_cnt) is built only when PIPE_STALL_CNT_EN is defined.
module pipe_stage_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
`ifdef PIPE_STALL_CNT_EN
    output logic [CNT_W-1:0]         stall_cnt,
`endif
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    if (DEPTH < 2 || (1 << PTR_W) != DEPTH || CNT_W < 1) begin : g_param_check
        $error("pipe_stage_buf: DEPTH must be a power of two >= 2 and CNT_W >= 1");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    // Handshake outputs depend on registered count only, never on out_ready.
    assign in_ready  = (count_q != OCC_FULL);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign occupancy = count_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        // A word handshaked during flush is dropped, and storage keeps its old contents.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + OCC_ONE;
                2'b01:   count_d = count_q - OCC_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    logic [CNT_W-1:0] stall_q, stall_d;

    assign stall_cnt = stall_q;

    // Counts cycles where the head is offered but refused; saturates instead of wrapping.
    always_comb begin
        stall_d = stall_q;
        if (flush) begin
            stall_d = '0;
        end else if (out_valid && !out_ready && stall_q != STALL_MAX) begin
            stall_d = stall_q + STALL_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed vector table, corner sequences and random traffic vs. a queue model.
module tb_pipe_stage_buf;

    localparam int W  = 8;
    localparam int D  = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [$clog2(D):0] occupancy;
`ifdef PIPE_STALL_CNT_EN
    logic [CW-1:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mq [$];
    int           m_stall = 0;

    always #5 clk = ~clk;

    pipe_stage_buf #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef PIPE_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .occupancy (occupancy)
    );

    typedef struct {
        bit           iv;
        logic [W-1:0] d;
        bit           ordy;
        bit           fl;
        int           occ;
        bit           ov;
        bit           ir;
        logic [W-1:0] dat;
        bit           chk_dat;
        int           stall;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " in_ready"}, 32'(in_ready), 32'(mq.size() != D));
        check({tag, " out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
        check({tag, " occupancy"}, 32'(occupancy), 32'(mq.size()));
        if (mq.size() != 0) begin
            check({tag, " out_data"}, 32'(out_data), 32'(mq[0]));
        end
`ifdef PIPE_STALL_CNT_EN
        check({tag, " stall_cnt"}, 32'(stall_cnt), 32'(m_stall));
`endif
    endtask

    // Drive one cycle, check the current state against the model, then advance model and clock.
    task automatic cycle(input bit iv, input logic [W-1:0] d, input bit ordy, input bit fl, input string tag);
        bit ov;
        bit ir;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        check_model(tag);
        ov = (mq.size() != 0);
        ir = (mq.size() != D);
        if (fl) begin
            mq.delete();
            m_stall = 0;
        end else begin
            if (ov && !ordy && m_stall < (1 << CW) - 1) m_stall++;
            if (ov && ordy) void'(mq.pop_front());
            if (ir && iv) mq.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'h11, 1'b1, 0};
        tbl[1]  = '{1'b1, 8'h22, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'h22, 1'b1, 0};
        tbl[2]  = '{1'b1, 8'h33, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'h33, 1'b1, 0};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b0, 0};
        tbl[4]  = '{1'b1, 8'h0A, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'h0A, 1'b1, 0};
        tbl[5]  = '{1'b1, 8'h0B, 1'b0, 1'b0, 2, 1'b1, 1'b0, 8'h0A, 1'b1, 1};
        tbl[6]  = '{1'b1, 8'h0C, 1'b0, 1'b0, 2, 1'b1, 1'b0, 8'h0A, 1'b1, 2};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'h0B, 1'b1, 2};
        tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b0, 2};
        tbl[9]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'h44, 1'b1, 2};
        tbl[10] = '{1'b1, 8'h05, 1'b1, 1'b0, 1, 1'b1, 1'b1, 8'h05, 1'b1, 2};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b0, 2};
        tbl[12] = '{1'b1, 8'h66, 1'b0, 1'b0, 1, 1'b1, 1'b1, 8'h66, 1'b1, 2};
        tbl[13] = '{1'b1, 8'h88, 1'b0, 1'b0, 2, 1'b1, 1'b0, 8'h66, 1'b1, 3};
        tbl[14] = '{1'b1, 8'h77, 1'b1, 1'b1, 0, 1'b0, 1'b1, 8'h00, 1'b0, 0};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 8'h00, 1'b0, 0};

        // Reset state while reset is held
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst occupancy", 32'(occupancy), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
`ifdef PIPE_STALL_CNT_EN
        check("rst stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, $sformatf("row%0d", i));
            $display("row %0d: iv=%0d d=%0h ordy=%0d fl=%0d -> occ=%0d ov=%0d ir=%0d data=%0h",
                     i, tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, occupancy, out_valid, in_ready, out_data);
            check($sformatf("row%0d occ", i), 32'(occupancy), 32'(tbl[i].occ));
            check($sformatf("row%0d ov", i), 32'(out_valid), 32'(tbl[i].ov));
            check($sformatf("row%0d ir", i), 32'(in_ready), 32'(tbl[i].ir));
            if (tbl[i].chk_dat) check($sformatf("row%0d data", i), 32'(out_data), 32'(tbl[i].dat));
`ifdef PIPE_STALL_CNT_EN
            check($sformatf("row%0d stall", i), 32'(stall_cnt), 32'(tbl[i].stall));
`endif
        end

        // Stall counter saturation, then flush
        cycle(1'b1, 8'h09, 1'b0, 1'b0, "stall_load");
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b0, $sformatf("stall%0d", k));
            $display("stall cycle %0d: occ=%0d", k, occupancy);
            check($sformatf("stall%0d occ", k), 32'(occupancy), 32'd1);
`ifdef PIPE_STALL_CNT_EN
            check($sformatf("stall%0d cnt", k), 32'(stall_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
`endif
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, "stall_flush");
        check("stall_flush occ", 32'(occupancy), 32'd0);
`ifdef PIPE_STALL_CNT_EN
        check("stall_flush cnt", 32'(stall_cnt), 32'd0);
`endif

        // Asynchronous reset mid-stream with two entries held
        cycle(1'b1, 8'hC1, 1'b0, 1'b0, "mid_a");
        cycle(1'b1, 8'hC2, 1'b0, 1'b0, "mid_b");
        check("mid occ before reset", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        $display("async reset: occ=%0d ov=%0d ir=%0d data=%0h", occupancy, out_valid, in_ready, out_data);
        check("async out_valid", 32'(out_valid), 32'd0);
        check("async in_ready", 32'(in_ready), 32'd1);
        check("async occupancy", 32'(occupancy), 32'd0);
        check("async out_data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mq.delete();
        m_stall = 0;
        check("post_reset out_data", 32'(out_data), 32'd0);
        check_model("post_reset");

        // Random traffic against the queue model
        for (int n = 0; n < 400; n++) begin
            bit           iv;
            bit           ordy;
            bit           fl;
            logic [W-1:0] d;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            fl   = ($urandom_range(0, 24) == 0);
            d    = W'($urandom_range(0, 255));
            cycle(iv, d, ordy, fl, $sformatf("rnd%0d", n));
            $display("rnd %0d: iv=%0d d=%0h ordy=%0d fl=%0d occ=%0d", n, iv, d, ordy, fl, occupancy);
        end
        check_model("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
